matrix_element_reader: RTL
==========================

# matrix_element_reader

Streams a flattened M×N matrix bus out one element per handshake. Each beat carries the element's row index, column index and value, so a downstream element-by-element matrix writer can rebuild the matrix in the pseudo-inverse datapath. Order is row-major, or column-major (transpose) when requested. The reader takes a snapshot of the matrix at start, so the source may change while a stream is in progress.

## Interface
- M, 4, number of rows
- N, 4, number of columns
- nBits, 32, element width and index width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a stream; sampled only in IDLE
- transpose  input  1  sampled with start; 1 selects column-major order
- matrix  input  M*N*nBits  flattened matrix; element (i,j) at bits [M*N*nBits-(N*i+j)*nBits-1 -: nBits], so (0,0) is in the MSBs
- ready  input  1  downstream can accept the current beat
- row  output  nBits  row index of the current beat
- column  output  nBits  column index of the current beat
- value  output  nBits  element value of the current beat
- valid  output  1  beat present on row/column/value
- busy  output  1  high in STREAM and DONE
- done  output  1  one-cycle pulse after the last beat transfers

## Operation
- States:
  - IDLE: valid=0, busy=0. When start=1: capture matrix into a snapshot register, latch transpose, set row=0 and column=0, go to STREAM.
  - STREAM: valid=1. A transfer occurs on a cycle where valid && ready.
    - Row-major (transpose=0): the column index increments; on wrap N-1→0 the row index increments.
    - Column-major (transpose=1): the row index increments; on wrap M-1→0 the column index increments.
    - When the transferred beat is (M-1,N-1), go to DONE.
  - DONE: valid=0, done=1 for exactly one cycle, then go to IDLE.
- value always equals snapshot[row][column]. row and column always report source coordinates, never transposed ones.
- While valid=1 and ready=0, row, column and value hold stable.
- start is ignored in STREAM and DONE. No queuing.
- Changes on matrix after capture have no effect on the current stream.
- Total beats per stream = M*N in both orders.
- Degenerate case M=N=1: a single beat (0,0), then DONE.

## Timing
- Reset values: row=0, column=0, value=0, valid=0, busy=0, done=0. The snapshot is cleared to 0 and the state is IDLE.
- Reset asserted mid-stream aborts immediately (asynchronous). No done pulse is produced.
- Start latency: start sampled high at edge t gives valid=1 with beat (0,0) after edge t.
- Throughput: one beat per cycle while ready is held high.
- With ready held high, a stream of M*N beats takes M*N cycles in STREAM plus 1 cycle in DONE.
- done is high in the cycle after the final transfer edge. busy falls with the transition to IDLE.
- Earliest restart: start may be accepted in the first IDLE cycle after DONE, which gives a 2-cycle gap between streams.
- Outputs are registered. No combinational path from ready to row, column or value; ready only gates advancement.

## Test plan
- Row-major, ready=1, M=N=2, nBits=8, matrix=0x11223344:
  - Required beats: (0,0,0x11), (0,1,0x22), (1,0,0x33), (1,1,0x44) on consecutive cycles.
  - Then done=1 for exactly one cycle.
- Transpose, same matrix:
  - Required beats: (0,0,0x11), (1,0,0x33), (0,1,0x22), (1,1,0x44).
- Backpressure: hold ready=0 for 3 cycles while the second beat is valid.
  - (0,1,0x22) stays stable, with no skipped or duplicated beats.
- Snapshot: change matrix to 0xFFFFFFFF one cycle after start.
  - The streamed values are still 0x11, 0x22, 0x33, 0x44.
- Start while busy: pulse start during STREAM.
  - Ignored. Exactly 4 beats and one done pulse.
- Reset mid-stream: assert reset after the second beat.
  - All outputs go to 0 immediately, with no done pulse.
  - A new start afterwards streams from (0,0).

Source files
------------

// File: rtl/matrix_element_reader.sv
// matrix_element_reader: streams a snapshot of a flattened M x N matrix out one
// element per valid/ready handshake, tagged with its source row and column.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for start; no beat presented
//   STREAM | beat on row/column/value, advances on valid && ready
//   DONE   | single-cycle done pulse after the final beat transferred
module matrix_element_reader #(
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int nBits = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   transpose,
  input  logic [M*N*nBits-1:0]   matrix,
  input  logic                   ready,
  output logic [nBits-1:0]       row,
  output logic [nBits-1:0]       column,
  output logic [nBits-1:0]       value,
  output logic                   valid,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [nBits-1:0] LAST_ROW = nBits'(M - 1);
  localparam logic [nBits-1:0] LAST_COL = nBits'(N - 1);
  localparam logic [nBits-1:0] IDX_ONE  = nBits'(1);
  localparam logic [nBits-1:0] IDX_ZERO = '0;

  state_t                 state_q, state_d;
  logic [M*N*nBits-1:0]   snap_q, snap_d;
  logic                   trans_q, trans_d;
  logic [nBits-1:0]       row_q, row_d;
  logic [nBits-1:0]       col_q, col_d;
  logic [nBits-1:0]       value_q, value_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [nBits-1:0]       nxt_row, nxt_col;
  logic                   last_beat;

  // Element (r,c) sits (N*r+c) elements below the MSB end of the flat bus.
  function automatic logic [nBits-1:0] elem(input logic [M*N*nBits-1:0] m,
                                            input logic [nBits-1:0]     r,
                                            input logic [nBits-1:0]     c);
    logic [M*N*nBits-1:0] sh;
    int                   idx;
    idx = N * int'(r) + int'(c);
    sh  = m >> (nBits * (M * N - 1 - idx));
    return sh[nBits-1:0];
  endfunction

  // Successor coordinates in the latched order; row/column stay source coordinates.
  always_comb begin
    nxt_row   = row_q;
    nxt_col   = col_q;
    last_beat = (row_q == LAST_ROW) && (col_q == LAST_COL);
    if (!trans_q) begin
      if (col_q == LAST_COL) begin
        nxt_col = IDX_ZERO;
        nxt_row = row_q + IDX_ONE;
      end else begin
        nxt_col = col_q + IDX_ONE;
      end
    end else begin
      if (row_q == LAST_ROW) begin
        nxt_row = IDX_ZERO;
        nxt_col = col_q + IDX_ONE;
      end else begin
        nxt_row = row_q + IDX_ONE;
      end
    end
  end

  // Next-state and next-output logic; all outputs are registered from these.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    trans_d = trans_q;
    row_d   = row_q;
    col_d   = col_q;
    value_d = value_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = matrix;
          trans_d = transpose;
          row_d   = IDX_ZERO;
          col_d   = IDX_ZERO;
          value_d = elem(matrix, IDX_ZERO, IDX_ZERO);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (valid_q && ready) begin
          if (last_beat) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            row_d   = nxt_row;
            col_d   = nxt_col;
            value_d = elem(snap_q, nxt_row, nxt_col);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, snapshot and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      trans_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      trans_q <= trans_d;
      row_q   <= row_d;
      col_q   <= col_d;
      value_q <= value_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign row    = row_q;
  assign column = col_q;
  assign value  = value_q;
  assign valid  = valid_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
